// File: rtl/voice_allocator_if.sv
// Note-event handshake between the event source and voice_allocator.
// A source drives ev_valid/ev_on/ev_note. The allocator answers with ev_ready.
interface voice_allocator_if #(
    parameter int NOTE_BITS = 7
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic                 ev_on;
    logic [NOTE_BITS-1:0] ev_note;

    modport master (output ev_valid, ev_on, ev_note, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler with LRU stealing.
// It accepts one note event at a time and then scans the voices, one per cycle.
// After the scan it commits the event to one voice. A retrigger or a steal
// holds that voice's gate low for RETRIG_CYCLES before raising it again.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_PEDAL_EN.
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int NOTE_BITS     = 7,
    parameter int RETRIG_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    voice_allocator_if.slave                ev,
    input  logic [NUM_VOICES-1:0]           voice_active_i,
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
    input  logic                            pedal_i,
`endif
    output logic [NUM_VOICES-1:0]           gate_o,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note_o,
    output logic                            steal_o
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NUM_VOICES - 1);
    localparam logic [CW-1:0] RLAST = CW'(RETRIG_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RETRIG} state_t;

    state_t state_q, state_d;

    // Per-voice state.
    logic [NUM_VOICES-1:0]                gate_q;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q;
    logic [NUM_VOICES-1:0][IW-1:0]        age_q;
    logic                                 steal_q;

    // Event that is currently in flight.
    logic                 on_q;
    logic [NOTE_BITS-1:0] enote_q;
    logic [IW-1:0]        scan_idx_q;

    // Candidates collected during the scan.
    logic          match_f_q, free_f_q, rel_f_q, steal_f_q;
    logic [IW-1:0] match_idx_q, free_idx_q, rel_idx_q, steal_idx_q;
    logic [IW-1:0] rel_age_q, steal_age_q;

    // Retrigger bookkeeping.
    logic [IW-1:0] ridx_q;
    logic [CW-1:0] rcnt_q;

    logic          accept, ev_ready, rel_now;
    logic [IW-1:0] sel;
    logic          go_retrig, is_steal;
    logic          cur_gate, cur_act;
    logic [NOTE_BITS-1:0] cur_note;
    logic [IW-1:0] cur_age;

`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] held_q;
    logic                  pedal_q, rel_pend_q, pedal_fall;
    assign pedal_fall = pedal_q && !pedal_i;
    // A pending pedal release runs only in IDLE. It wins over a new event.
    assign rel_now    = (state_q == S_IDLE) && (rel_pend_q || pedal_fall);
`else
    assign rel_now    = 1'b0;
`endif

    assign cur_gate = gate_q[scan_idx_q];
    assign cur_act  = voice_active_i[scan_idx_q];
    assign cur_note = note_q[scan_idx_q];
    assign cur_age  = age_q[scan_idx_q];

    // Note-on target priority: retrigger, then free, then releasing, then steal.
    always_comb begin
        if (match_f_q)     sel = match_idx_q;
        else if (free_f_q) sel = free_idx_q;
        else if (rel_f_q)  sel = rel_idx_q;
        else               sel = steal_idx_q;
    end

    assign go_retrig = on_q && (match_f_q || (!free_f_q && !rel_f_q));
    assign is_steal  = on_q && !match_f_q && !free_f_q && !rel_f_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and handshake.
    always_comb begin
        state_d  = state_q;
        ev_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ev_ready = !rel_now;
                if (ev.ev_valid && !rel_now) begin
                    accept  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN:   if (scan_idx_q == LAST) state_d = S_COMMIT;
            S_COMMIT: state_d = go_retrig ? S_RETRIG : S_IDLE;
            S_RETRIG: if (rcnt_q == RLAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign ev.ev_ready  = ev_ready;
    assign gate_o       = gate_q;
    assign voice_note_o = note_q;
    assign steal_o      = steal_q;

    // Datapath: latch the event, scan the voices, commit, retrigger and age.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q      <= '0;
            note_q      <= '0;
            steal_q     <= 1'b0;
            on_q        <= 1'b0;
            enote_q     <= '0;
            scan_idx_q  <= '0;
            match_f_q   <= 1'b0;
            free_f_q    <= 1'b0;
            rel_f_q     <= 1'b0;
            steal_f_q   <= 1'b0;
            match_idx_q <= '0;
            free_idx_q  <= '0;
            rel_idx_q   <= '0;
            steal_idx_q <= '0;
            rel_age_q   <= '0;
            steal_age_q <= '0;
            ridx_q      <= '0;
            rcnt_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= IW'(i);
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
            held_q      <= '0;
            pedal_q     <= 1'b0;
            rel_pend_q  <= 1'b0;
`endif
        end else begin
            steal_q <= 1'b0;

            if (accept) begin
                on_q       <= ev.ev_on;
                enote_q    <= ev.ev_note;
                scan_idx_q <= '0;
                match_f_q  <= 1'b0;
                free_f_q   <= 1'b0;
                rel_f_q    <= 1'b0;
                steal_f_q  <= 1'b0;
            end

            if (state_q == S_SCAN) begin
                scan_idx_q <= scan_idx_q + 1'b1;
                // The first gated voice with the same note is the retrigger or note-off target.
                if (cur_gate && cur_note == enote_q && !match_f_q) begin
                    match_f_q   <= 1'b1;
                    match_idx_q <= scan_idx_q;
                end
                if (!cur_gate && !cur_act && !free_f_q) begin
                    free_f_q   <= 1'b1;
                    free_idx_q <= scan_idx_q;
                end
                if (!cur_gate && cur_act && (!rel_f_q || cur_age > rel_age_q)) begin
                    rel_f_q   <= 1'b1;
                    rel_idx_q <= scan_idx_q;
                    rel_age_q <= cur_age;
                end
                if (cur_gate && (!steal_f_q || cur_age > steal_age_q)) begin
                    steal_f_q   <= 1'b1;
                    steal_idx_q <= scan_idx_q;
                    steal_age_q <= cur_age;
                end
            end

            if (state_q == S_COMMIT) begin
                if (on_q) begin
                    note_q[sel] <= enote_q;
                    gate_q[sel] <= !go_retrig;
                    steal_q     <= is_steal;
                    ridx_q      <= sel;
                    rcnt_q      <= '0;
                    // LRU update: voices younger than the chosen one age by one.
                    for (int j = 0; j < NUM_VOICES; j++)
                        if (age_q[j] < age_q[sel]) age_q[j] <= age_q[j] + 1'b1;
                    age_q[sel] <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
                    held_q[sel] <= 1'b0;
`endif
                end else if (match_f_q) begin
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
                    if (pedal_i) held_q[match_idx_q] <= 1'b1;
                    else         gate_q[match_idx_q] <= 1'b0;
`else
                    gate_q[match_idx_q] <= 1'b0;
`endif
                end
            end

            if (state_q == S_RETRIG) begin
                if (rcnt_q == RLAST) gate_q[ridx_q] <= 1'b1;
                else                 rcnt_q <= rcnt_q + 1'b1;
            end

`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
            pedal_q <= pedal_i;
            if (rel_now) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    if (held_q[i]) gate_q[i] <= 1'b0;
                held_q     <= '0;
                rel_pend_q <= 1'b0;
            end else if (pedal_fall) begin
                rel_pend_q <= 1'b1;
            end
`endif
        end
    end
endmodule
